// File: rtl/dodge_core_n.sv
// dodge_core_n: falling-obstacle dodge game engine driving a scanned active-low RGB matrix
module dodge_core_n #(
   parameter int COLS      = 8,
   parameter int ROWS      = 8,
   parameter int TICK_DIV  = 50000,
   parameter int FALL_INIT = 200,
   parameter int FALL_MIN  = 40,
   parameter int FALL_DEC  = 20,
   parameter int LEVEL_PTS = 16,
   parameter int LIVES     = 3,
   parameter int HIT_TICKS = 400,
   parameter int SCORE_W   = 8
) (
   input  logic                  CLK,
   input  logic                  RST_N,
   input  logic                  START,
   input  logic                  LEFT,
   input  logic                  RIGHT,
   output logic [COLS-1:0]       DATA_R,
   output logic [COLS-1:0]       DATA_G,
   output logic [COLS-1:0]       DATA_B,
   output logic [$clog2(ROWS):0] COMM,
   output logic [SCORE_W-1:0]    SCORE,
   output logic [2:0]            LIVES_LEFT,
   output logic [1:0]            STATE
);
   localparam int RW = $clog2(ROWS);
   localparam int CW = $clog2(COLS);
   localparam int TW = $clog2(TICK_DIV + 1);
   typedef enum logic [1:0] {IDLE, PLAY, HIT, OVER} state_t;
   state_t state, state_nx;
   logic [TW-1:0] tick_cnt;
   logic tick, tick_d, fall;
   logic [RW-1:0] row;
   logic [COLS-1:0] field [ROWS];
   logic [COLS-1:0] field_nx [ROWS];
   logic [CW-1:0] col, col_nx;
   logic [15:0] lfsr, lfsr_nx, fall_cnt, fall_cnt_nx, hit_cnt, hit_cnt_nx, period;
   logic [SCORE_W-1:0] score_nx;
   logic [2:0] lives_nx;
   logic [31:0] dec;
   logic [COLS-1:0] r_nx, b_nx;
   int k;
   assign STATE = state;
   assign tick = tick_cnt == TW'(TICK_DIV - 1);
   assign dec = 32'(SCORE) / 32'(LEVEL_PTS) * 32'(FALL_DEC);
   assign period = (dec + 32'(FALL_MIN) >= 32'(FALL_INIT)) ? 16'(FALL_MIN) : 16'(32'(FALL_INIT) - dec);
   assign fall = state == PLAY && tick && fall_cnt + 16'd1 >= period;
   // game next state: abort/idle init, moves, fall steps, collisions and the hit pause
   always_comb begin
      state_nx = state;
      field_nx = field;
      col_nx = col;
      lfsr_nx = lfsr;
      fall_cnt_nx = fall_cnt;
      hit_cnt_nx = hit_cnt;
      score_nx = SCORE;
      lives_nx = LIVES_LEFT;
      if (!START || state == IDLE) begin
         state_nx = START ? PLAY : IDLE;
         field_nx = '{default: '0};
         col_nx = CW'(COLS / 2);
         fall_cnt_nx = '0;
         hit_cnt_nx = '0;
         score_nx = '0;
         lives_nx = 3'(LIVES);
      end else if (state == PLAY) begin
         if (LEFT && !RIGHT && col != '0) col_nx = col - 1'b1;
         if (RIGHT && !LEFT && col != CW'(COLS - 1)) col_nx = col + 1'b1;
         if (tick) fall_cnt_nx = fall ? '0 : fall_cnt + 16'd1;
         if (fall) begin
            for (int r = ROWS - 1; r > 0; r--) field_nx[r] = field[r-1];
            field_nx[0] = lfsr[15] ? COLS'(1) << (32'(lfsr[3:0]) % COLS) : '0;
            lfsr_nx = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            if (|field[ROWS-1] && SCORE != '1) score_nx = SCORE + 1'b1;
         end
         if (field_nx[ROWS-1][col_nx]) begin
            field_nx = '{default: '0};
            lives_nx = LIVES_LEFT - 1'b1;
            hit_cnt_nx = '0;
            state_nx = HIT;
         end
      end else if (state == HIT && tick) begin
         hit_cnt_nx = hit_cnt + 16'd1;
         if (hit_cnt == 16'(HIT_TICKS - 1)) begin
            state_nx = LIVES_LEFT != 3'd0 ? PLAY : OVER;
            fall_cnt_nx = '0;
            hit_cnt_nx = '0;
         end
      end
   end
   // game and scan state registers
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state <= IDLE;
         field <= '{default: '0};
         col <= CW'(COLS / 2);
         lfsr <= 16'hACE1;
         fall_cnt <= '0;
         hit_cnt <= '0;
         SCORE <= '0;
         LIVES_LEFT <= 3'(LIVES);
         tick_cnt <= '0;
         tick_d <= 1'b0;
         row <= '0;
      end else begin
         state <= state_nx;
         field <= field_nx;
         col <= col_nx;
         lfsr <= lfsr_nx;
         fall_cnt <= fall_cnt_nx;
         hit_cnt <= hit_cnt_nx;
         SCORE <= score_nx;
         LIVES_LEFT <= lives_nx;
         tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
         tick_d <= tick;
         if (tick) row <= row == RW'(ROWS - 1) ? '0 : row + 1'b1;
      end
   end
   // pixel content of the scanned row: obstacles red, player blue, red X when game over
   always_comb begin
      k = 32'(row) % COLS;
      r_nx = state == OVER ? ~((COLS'(1) << k) | (COLS'(1) << (COLS - 1 - k))) : ~field[row];
      b_nx = row == RW'(ROWS - 1) && (state == PLAY || (state == HIT && !hit_cnt[5])) ? ~(COLS'(1) << col) : '1;
   end
   // display registers load one clock after each scan tick and stay blank while idle
   always_ff @(posedge CLK) begin
      if (!RST_N || state == IDLE) begin
         DATA_R <= '1;
         DATA_G <= '1;
         DATA_B <= '1;
         COMM <= '0;
      end else if (tick_d) begin
         DATA_R <= r_nx;
         DATA_G <= '1;
         DATA_B <= b_nx;
         COMM <= {1'b1, row};
      end
   end
endmodule

// File: tb/tb_dodge_core_n.sv
// tb_dodge_core_n: randomized and policy-driven game play checked against a behavioural game model
module tb_dodge_core_n;
   localparam int C = 4, R = 4, TD = 2, FI = 4, FM = 2, FD = 1, LP = 2, LV = 2, HT = 8;
   logic CLK = 1'b0, RST_N = 1'b0, START = 1'b0, LEFT = 1'b0, RIGHT = 1'b0;
   logic [3:0] DATA_R, DATA_G, DATA_B;
   logic [2:0] COMM;
   logic [7:0] SCORE;
   logic [2:0] LIVES_LEFT;
   logic [1:0] STATE;
   int vectors = 0, errors = 0;
   int cyc, m_state, m_col, m_score, m_lives, m_fall, m_hit;
   int obs [R];
   logic [15:0] m_lfsr;
   logic [3:0] m_r, m_b;
   logic [2:0] m_comm;
   dodge_core_n #(.COLS(C), .ROWS(R), .TICK_DIV(TD), .FALL_INIT(FI), .FALL_MIN(FM), .FALL_DEC(FD),
                  .LEVEL_PTS(LP), .LIVES(LV), .HIT_TICKS(HT), .SCORE_W(8)) dut (
      .CLK(CLK), .RST_N(RST_N), .START(START), .LEFT(LEFT), .RIGHT(RIGHT),
      .DATA_R(DATA_R), .DATA_G(DATA_G), .DATA_B(DATA_B), .COMM(COMM),
      .SCORE(SCORE), .LIVES_LEFT(LIVES_LEFT), .STATE(STATE));
   always #5 CLK = ~CLK;
   // game model advanced once per clock edge from the pre-edge state and inputs
   task automatic model_edge();
      bit tk;
      int row, period;
      if (!RST_N) begin
         cyc = 0; m_state = 0; m_col = C / 2; m_score = 0; m_lives = LV; m_fall = 0; m_hit = 0;
         m_lfsr = 16'hACE1; m_r = 4'hF; m_b = 4'hF; m_comm = 3'd0;
         foreach (obs[i]) obs[i] = -1;
         return;
      end
      tk = (cyc % TD) == TD - 1;
      row = (cyc / TD) % R;
      if (m_state == 0) begin
         m_r = 4'hF; m_b = 4'hF; m_comm = 3'd0;
      end else if (cyc > 0 && cyc % TD == 0) begin
         m_comm = 3'(4 + row); m_r = 4'hF; m_b = 4'hF;
         if (m_state == 3) begin m_r[row % C] = 1'b0; m_r[C - 1 - row % C] = 1'b0; end
         else if (obs[row] >= 0) m_r[obs[row]] = 1'b0;
         if (row == R - 1 && (m_state == 1 || (m_state == 2 && (m_hit / 32) % 2 == 0))) m_b[m_col] = 1'b0;
      end
      if (!START || m_state == 0) begin
         m_state = START ? 1 : 0; m_col = C / 2; m_score = 0; m_lives = LV; m_fall = 0; m_hit = 0;
         foreach (obs[i]) obs[i] = -1;
      end else if (m_state == 1) begin
         if (LEFT && !RIGHT && m_col > 0) m_col--;
         if (RIGHT && !LEFT && m_col < C - 1) m_col++;
         if (tk) begin
            period = FI - (m_score / LP) * FD;
            if (period < FM) period = FM;
            m_fall++;
            if (m_fall >= period) begin
               m_fall = 0;
               if (obs[R-1] >= 0 && m_score < 255) m_score++;
               for (int i = R - 1; i > 0; i--) obs[i] = obs[i-1];
               obs[0] = m_lfsr[15] ? int'(m_lfsr[3:0]) % C : -1;
               m_lfsr = {m_lfsr[14:0], ^(m_lfsr & 16'hB400)};
            end
         end
         if (obs[R-1] == m_col) begin
            foreach (obs[i]) obs[i] = -1;
            m_lives--; m_hit = 0; m_state = 2;
         end
      end else if (m_state == 2 && tk) begin
         m_hit++;
         if (m_hit == HT) begin m_state = m_lives > 0 ? 1 : 3; m_fall = 0; m_hit = 0; end
      end
      cyc++;
   endtask
   task automatic clk1();
      @(posedge CLK);
      model_edge();
      #1;
   endtask
   function automatic logic [27:0] dut_vec();
      return {STATE, SCORE, LIVES_LEFT, COMM, DATA_R, DATA_G, DATA_B};
   endfunction
   function automatic logic [27:0] mdl_vec();
      return {2'(m_state), 8'(m_score), 3'(m_lives), m_comm, m_r, 4'hF, m_b};
   endfunction
   function automatic int hunt_dir();
      for (int i = R - 1; i >= 0; i--) if (obs[i] >= 0) return obs[i] > m_col ? 1 : obs[i] < m_col ? -1 : 0;
      return 0;
   endfunction
   function automatic int dodge_dir();
      for (int d = 0; d < C; d++)
         for (int s = -1; s <= 1; s += 2) begin
            int c;
            c = m_col + s * d;
            if (c >= 0 && c < C && c != obs[R-1] && c != obs[R-2] &&
                !(obs[R-1] >= 0 && (obs[R-1] - m_col) * (obs[R-1] - c) < 0))
               return c > m_col ? 1 : c < m_col ? -1 : 0;
         end
      return 0;
   endfunction
   task automatic test_reset();
      RST_N = 1'b0; START = 1'b0; LEFT = 1'b0; RIGHT = 1'b0;
      repeat (3) clk1();
      vectors++; if ({DATA_R, DATA_G, DATA_B} !== 12'hFFF) begin errors++; $display("FAIL reset_data: got %h want fff", {DATA_R, DATA_G, DATA_B}); end
      vectors++; if (COMM !== 3'd0) begin errors++; $display("FAIL reset_comm: got %0d want 0", COMM); end
      vectors++; if ({STATE, SCORE, LIVES_LEFT} !== {2'd0, 8'd0, 3'd2}) begin errors++; $display("FAIL reset_status: got %h want %h", {STATE, SCORE, LIVES_LEFT}, {2'd0, 8'd0, 3'd2}); end
      RST_N = 1'b1;
   endtask
   task automatic test_start();
      START = 1'b1;
      clk1();
      vectors++; if (STATE !== 2'd1) begin errors++; $display("FAIL start_state: got %0d want 1", STATE); end
      vectors++; if (dut_vec() !== mdl_vec()) begin errors++; $display("FAIL start cyc %0d: dut %h model %h", cyc, dut_vec(), mdl_vec()); end
   endtask
   task automatic test_move();
      int n;
      repeat (5) begin
         LEFT = 1'b1; clk1(); LEFT = 1'b0;
         vectors++; if (dut_vec() !== mdl_vec()) begin errors++; $display("FAIL move cyc %0d: dut %h model %h", cyc, dut_vec(), mdl_vec()); end
         clk1();
      end
      LEFT = 1'b1; RIGHT = 1'b1; clk1(); LEFT = 1'b0; RIGHT = 1'b0;
      repeat (2) clk1();
      n = 0;
      while (COMM !== 3'd7 && n < 10) begin
         clk1(); n++;
         vectors++; if (dut_vec() !== mdl_vec()) begin errors++; $display("FAIL move_wait cyc %0d: dut %h model %h", cyc, dut_vec(), mdl_vec()); end
      end
      vectors++; if (DATA_B !== 4'b1110) begin errors++; $display("FAIL clamp_col0: DATA_B got %b want 1110", DATA_B); end
   endtask
   task automatic test_scan();
      logic [2:0] prev, want;
      int n;
      prev = COMM;
      for (int i = 0; i < 8; i++) begin
         n = 0;
         do begin
            clk1(); n++;
            vectors++; if (dut_vec() !== mdl_vec()) begin errors++; $display("FAIL scan cyc %0d: dut %h model %h", cyc, dut_vec(), mdl_vec()); end
         end while (COMM === prev && n < 4);
         want = prev == 3'd7 ? 3'd4 : prev + 3'd1;
         vectors++; if (COMM !== want) begin errors++; $display("FAIL scan_seq: COMM got %0d want %0d", COMM, want); end
         prev = COMM;
      end
   endtask
   task automatic test_dodge();
      int n, d;
      n = 0;
      while (m_score < 4 && n < 3000) begin
         d = dodge_dir();
         LEFT = m_state == 1 && d < 0; RIGHT = m_state == 1 && d > 0;
         START = m_state != 3;
         clk1(); n++;
         vectors++; if (dut_vec() !== mdl_vec()) begin errors++; $display("FAIL dodge cyc %0d: dut %h model %h", cyc, dut_vec(), mdl_vec()); end
      end
      vectors++; if (n == 3000) begin errors++; $display("FAIL dodge_timeout: score got %0d want 4", SCORE); end
      vectors++; if (SCORE !== 8'd4) begin errors++; $display("FAIL dodge_score: got %0d want 4", SCORE); end
      repeat (80) begin
         d = dodge_dir();
         LEFT = m_state == 1 && d < 0; RIGHT = m_state == 1 && d > 0;
         START = m_state != 3;
         clk1();
         vectors++; if (dut_vec() !== mdl_vec()) begin errors++; $display("FAIL fall_min cyc %0d: dut %h model %h", cyc, dut_vec(), mdl_vec()); end
      end
      LEFT = 1'b0; RIGHT = 1'b0; START = 1'b1;
   endtask
   task automatic test_abort();
      START = 1'b0; clk1();
      vectors++; if ({STATE, SCORE} !== 10'd0) begin errors++; $display("FAIL abort_status: got %h want 000", {STATE, SCORE}); end
      clk1();
      vectors++; if ({COMM, DATA_R, DATA_G, DATA_B} !== 15'h0FFF) begin errors++; $display("FAIL abort_blank: got %h want 0fff", {COMM, DATA_R, DATA_G, DATA_B}); end
      START = 1'b1; clk1();
      vectors++; if (dut_vec() !== mdl_vec()) begin errors++; $display("FAIL restart cyc %0d: dut %h model %h", cyc, dut_vec(), mdl_vec()); end
   endtask
   task automatic hunt_until(input int target, input int bound);
      int n, d;
      n = 0;
      while (m_state != target && n < bound) begin
         d = hunt_dir();
         LEFT = m_state == 1 && d < 0; RIGHT = m_state == 1 && d > 0;
         clk1(); n++;
         vectors++; if (dut_vec() !== mdl_vec()) begin errors++; $display("FAIL hunt cyc %0d: dut %h model %h", cyc, dut_vec(), mdl_vec()); end
      end
      LEFT = 1'b0; RIGHT = 1'b0;
      vectors++; if (n == bound) begin errors++; $display("FAIL hunt_timeout: state got %0d want %0d", STATE, target); end
   endtask
   task automatic test_collision();
      int n;
      hunt_until(2, 800);
      vectors++; if ({STATE, LIVES_LEFT} !== {2'd2, 3'd1}) begin errors++; $display("FAIL hit_entry: got %h want %h", {STATE, LIVES_LEFT}, {2'd2, 3'd1}); end
      n = 0;
      while (STATE === 2'd2 && n < 40) begin
         clk1(); n++;
         vectors++; if (dut_vec() !== mdl_vec()) begin errors++; $display("FAIL hit cyc %0d: dut %h model %h", cyc, dut_vec(), mdl_vec()); end
      end
      vectors++; if (n < HT * TD - 1 || n > HT * TD) begin errors++; $display("FAIL hit_len: got %0d clocks want %0d", n + 1, HT * TD); end
      vectors++; if (STATE !== 2'd1) begin errors++; $display("FAIL hit_exit: state got %0d want 1", STATE); end
   endtask
   task automatic test_game_over();
      logic [7:0] s0;
      logic [3:0] x;
      hunt_until(3, 1200);
      vectors++; if ({STATE, LIVES_LEFT} !== {2'd3, 3'd0}) begin errors++; $display("FAIL over_entry: got %h want %h", {STATE, LIVES_LEFT}, {2'd3, 3'd0}); end
      s0 = 8'(m_score);
      repeat (16) begin
         LEFT = $urandom_range(0, 1) == 0; RIGHT = $urandom_range(0, 1) == 0;
         clk1();
         vectors++; if (SCORE !== s0) begin errors++; $display("FAIL over_score: got %0d want %0d", SCORE, s0); end
         if (COMM[2]) begin
            x = 4'hF; x[COMM[1:0]] = 1'b0; x[3 - COMM[1:0]] = 1'b0;
            vectors++; if (DATA_R !== x) begin errors++; $display("FAIL over_x row %0d: DATA_R got %b want %b", COMM[1:0], DATA_R, x); end
         end
      end
      LEFT = 1'b0; RIGHT = 1'b0;
   endtask
   task automatic test_reset_mid_hit();
      START = 1'b0; clk1(); START = 1'b1; clk1();
      hunt_until(2, 800);
      repeat (3) clk1();
      RST_N = 1'b0; clk1();
      vectors++; if (dut_vec() !== {2'd0, 8'd0, 3'd2, 3'd0, 12'hFFF}) begin errors++; $display("FAIL reset_mid_hit: got %h want %h", dut_vec(), {2'd0, 8'd0, 3'd2, 3'd0, 12'hFFF}); end
      RST_N = 1'b1;
   endtask
   task automatic test_random();
      repeat (1500) begin
         LEFT = $urandom_range(0, 3) == 0; RIGHT = $urandom_range(0, 3) == 0;
         START = $urandom_range(0, 99) != 0;
         clk1();
         vectors++; if (dut_vec() !== mdl_vec()) begin errors++; $display("FAIL random cyc %0d: dut %h model %h", cyc, dut_vec(), mdl_vec()); end
      end
   endtask
   initial begin
      test_reset();
      test_start();
      test_move();
      test_scan();
      test_dodge();
      test_abort();
      test_collision();
      test_game_over();
      test_reset_mid_hit();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
